// File: rtl/glb_token_arbiter_rr_pkg.sv
// rtl/glb_token_arbiter_rr_pkg.sv - shared types for the GLB token arbiter
package glb_arb_pkg;

    typedef enum logic [1:0] {
        CLS_IFMAP = 2'd0,
        CLS_IPSUM = 2'd1,
        CLS_OPSUM = 2'd2
    } cls_e;

    localparam logic [3:0] WEB_READ = 4'hF;
    localparam int         TAG_CH_W = 6;

    typedef struct packed {
        cls_e                cls;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

    // Round-robin class order ifmap -> ipsum -> opsum -> ifmap.
    function automatic cls_e cls_next(input cls_e c);
        case (c)
            CLS_IFMAP: return CLS_IPSUM;
            CLS_IPSUM: return CLS_OPSUM;
            default:   return CLS_IFMAP;
        endcase
    endfunction

endpackage

// File: rtl/glb_token_arbiter_rr_if.sv
// rtl/glb_token_arbiter_rr_if.sv - GLB command port and tagged read-return bundle
interface glb_token_arbiter_rr_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CH_W   = 5
);
    logic                    glb_en;
    logic [3:0]              glb_web;
    logic [ADDR_W-1:0]       glb_addr;
    logic [DATA_W-1:0]       glb_wdata;
    logic [DATA_W-1:0]       glb_rdata;
    logic                    rd_valid;
    glb_arb_pkg::cls_e       rd_cls;
    logic [CH_W-1:0]         rd_ch;
    logic [DATA_W-1:0]       rd_data;
    logic                    busy;

    modport master (
        output glb_en, glb_web, glb_addr, glb_wdata,
        input  glb_rdata,
        output rd_valid, rd_cls, rd_ch, rd_data, busy
    );

    modport slave (
        input  glb_en, glb_web, glb_addr, glb_wdata,
        output glb_rdata,
        input  rd_valid, rd_cls, rd_ch, rd_data, busy
    );
endinterface

// File: rtl/glb_token_arbiter_rr_pick.sv
// rtl/glb_token_arbiter_rr_pick.sv - one-hot round-robin picker starting at ptr_i
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);
    int pos;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx_o = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) pos = pos - N;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/glb_token_arbiter_rr.sv
// rtl/glb_token_arbiter_rr.sv - three-class GLB arbiter with tagged read return
module glb_token_arbiter_rr
    import glb_arb_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ifmap_req_i,
    input  logic [NUM_CH-1:0]        ipsum_req_i,
    input  logic [NUM_CH-1:0]        opsum_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] ifmap_addr_i,
    input  logic [NUM_CH*ADDR_W-1:0] ipsum_addr_i,
    input  logic [NUM_CH*ADDR_W-1:0] opsum_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] opsum_data_i,
    input  logic [NUM_CH*4-1:0]      opsum_web_i,
    input  logic                     prio_mode_i,
    output logic [NUM_CH-1:0]        ifmap_gnt_o,
    output logic [NUM_CH-1:0]        ipsum_gnt_o,
    output logic [NUM_CH-1:0]        opsum_gnt_o,
    glb_token_arbiter_rr_if.master   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] req   [3];
    logic [NUM_CH-1:0] pgnt  [3];
    logic [2:0]        pany;
    logic [CH_W-1:0]   pidx  [3];
    logic [CH_W-1:0]   ptr_q [3];
    logic [CH_W-1:0]   ptr_d [3];
    cls_e              last_cls_q;
    cls_e              sel_cls;
    cls_e              srch;
    logic              sel_vld;
    logic [CH_W-1:0]   sel_idx;
    logic              rd_gnt;
    tag_t              rd_tag;
    logic [RD_LAT-1:0] vld_q;
    tag_t              tag_q [RD_LAT];
    tag_t              tag_out;
    logic              unused_tag;

    assign req[0] = ifmap_req_i;
    assign req[1] = ipsum_req_i;
    assign req[2] = opsum_req_i;

    for (genvar c = 0; c < 3; c++) begin : g_pick
        rr_pick #(.N(NUM_CH), .IW(CH_W)) u_pick (
            .req_i (req[c]),
            .ptr_i (ptr_q[c]),
            .gnt_o (pgnt[c]),
            .any_o (pany[c]),
            .idx_o (pidx[c])
        );
        assign ptr_d[c] = (pidx[c] == CH_W'(NUM_CH - 1)) ? '0 : pidx[c] + 1'b1;
    end

    // last_cls_q holds the last granted class, so the RR search begins one past it.
    always_comb begin
        sel_vld = 1'b0;
        sel_cls = CLS_IFMAP;
        srch    = cls_next(last_cls_q);
        if (!prio_mode_i) begin
            if (pany[2])      begin sel_vld = 1'b1; sel_cls = CLS_OPSUM; end
            else if (pany[0]) begin sel_vld = 1'b1; sel_cls = CLS_IFMAP; end
            else if (pany[1]) begin sel_vld = 1'b1; sel_cls = CLS_IPSUM; end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!sel_vld && pany[int'(srch)]) begin
                    sel_vld = 1'b1;
                    sel_cls = srch;
                end
                srch = cls_next(srch);
            end
        end
        if (rst) sel_vld = 1'b0;
    end

    always_comb begin
        sel_idx       = '0;
        bus.glb_en    = sel_vld;
        bus.glb_web   = WEB_READ;
        bus.glb_addr  = '0;
        bus.glb_wdata = '0;
        case (sel_cls)
            CLS_IFMAP: sel_idx = pidx[0];
            CLS_IPSUM: sel_idx = pidx[1];
            default:   sel_idx = pidx[2];
        endcase
        if (sel_vld) begin
            case (sel_cls)
                CLS_IFMAP: bus.glb_addr = ifmap_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
                CLS_IPSUM: bus.glb_addr = ipsum_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
                default: begin
                    bus.glb_addr  = opsum_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
                    bus.glb_web   = opsum_web_i[int'(sel_idx)*4 +: 4];
                    bus.glb_wdata = opsum_data_i[int'(sel_idx)*DATA_W +: DATA_W];
                end
            endcase
        end
    end

    assign ifmap_gnt_o = (sel_vld && sel_cls == CLS_IFMAP) ? pgnt[0] : '0;
    assign ipsum_gnt_o = (sel_vld && sel_cls == CLS_IPSUM) ? pgnt[1] : '0;
    assign opsum_gnt_o = (sel_vld && sel_cls == CLS_OPSUM) ? pgnt[2] : '0;

    assign rd_gnt     = sel_vld && (sel_cls != CLS_OPSUM);
    assign rd_tag.cls = sel_cls;
    assign rd_tag.ch  = TAG_CH_W'(sel_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) ptr_q[c] <= '0;
            last_cls_q <= CLS_OPSUM;
            vld_q      <= '0;
        end else begin
            if (sel_vld) begin
                last_cls_q <= sel_cls;
                for (int c = 0; c < 3; c++)
                    if (sel_cls == cls_e'(c)) ptr_q[c] <= ptr_d[c];
            end
            vld_q[0] <= rd_gnt;
            for (int k = 1; k < RD_LAT; k++) vld_q[k] <= vld_q[k-1];
        end
        tag_q[0] <= rd_tag;
        for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end

    assign tag_out      = tag_q[RD_LAT-1];
    assign bus.rd_valid = vld_q[RD_LAT-1] && !rst;
    assign bus.rd_cls   = tag_out.cls;
    assign bus.rd_ch    = tag_out.ch[CH_W-1:0];
    assign bus.rd_data  = bus.rd_valid ? bus.glb_rdata : '0;
    assign bus.busy     = !rst && (rd_gnt || (|vld_q));
    assign unused_tag   = ^tag_out.ch;
endmodule

// File: tb/tb_glb_token_arbiter_rr.sv
// tb/tb_glb_token_arbiter_rr.sv - self-checking bench for glb_token_arbiter_rr
module tb_glb_token_arbiter_rr;
    import glb_arb_pkg::*;

    localparam int N   = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int CW  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ifmap_req = '0, ipsum_req = '0, opsum_req = '0;
    logic [N*AW-1:0] ifmap_addr = '0, ipsum_addr = '0, opsum_addr = '0;
    logic [N*DW-1:0] opsum_data = '0;
    logic [N*4-1:0]  opsum_web = '1;
    logic            prio = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic [N-1:0]    ifmap_gnt, ipsum_gnt, opsum_gnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int due;
        int cls;
        int ch;
    } ret_t;

    int   m_ptr [3];
    int   m_last;
    int   cyc = 0;
    int   e_cls, e_ch;
    ret_t rq [$];

    logic [N-1:0]  snap_gnt [3];
    logic          snap_en, snap_rdv, snap_busy;
    logic [3:0]    snap_web;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata, snap_rdata;
    logic [CW-1:0] snap_rch;
    logic [1:0]    snap_rcls;

    logic [N-1:0]  exp39 [4] = '{8'h01, 8'h02, 8'h08, 8'h01};
    int            exp40 [4] = '{0, 1, 2, 0};

    glb_token_arbiter_rr_if #(.ADDR_W(AW), .DATA_W(DW), .CH_W(CW)) bus ();

    glb_token_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifmap_req_i  (ifmap_req),
        .ipsum_req_i  (ipsum_req),
        .opsum_req_i  (opsum_req),
        .ifmap_addr_i (ifmap_addr),
        .ipsum_addr_i (ipsum_addr),
        .opsum_addr_i (opsum_addr),
        .opsum_data_i (opsum_data),
        .opsum_web_i  (opsum_web),
        .prio_mode_i  (prio),
        .ifmap_gnt_o  (ifmap_gnt),
        .ipsum_gnt_o  (ipsum_gnt),
        .opsum_gnt_o  (opsum_gnt),
        .bus          (bus)
    );

    assign bus.glb_rdata = rdata;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] req_of(input int c);
        case (c)
            0:       return ifmap_req;
            1:       return ipsum_req;
            default: return opsum_req;
        endcase
    endfunction

    // Reference arbitration: class order from the mode, then first requester from the class pointer.
    task automatic predict();
        int order [3];
        logic [N-1:0] r;
        e_cls = -1;
        e_ch  = -1;
        if (!prio) order = '{2, 0, 1};
        else for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
        for (int k = 0; k < 3; k++) begin
            if (e_cls < 0 && req_of(order[k]) != '0) begin
                e_cls = order[k];
                r = req_of(e_cls);
                for (int i = 0; i < N; i++)
                    if (e_ch < 0 && r[(m_ptr[e_cls] + i) % N]) e_ch = (m_ptr[e_cls] + i) % N;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0]  eg [3];
        logic [AW-1:0] ea;
        logic [3:0]    ew;
        logic [DW-1:0] ed;
        bit            ev, eb;
        ret_t          r;
        predict();
        @(negedge clk);
        for (int c = 0; c < 3; c++) eg[c] = '0;
        ea = '0; ew = 4'hF; ed = '0;
        if (e_cls >= 0) eg[e_cls][e_ch] = 1'b1;
        case (e_cls)
            0: ea = ifmap_addr[e_ch*AW +: AW];
            1: ea = ipsum_addr[e_ch*AW +: AW];
            2: begin
                ea = opsum_addr[e_ch*AW +: AW];
                ew = opsum_web[e_ch*4 +: 4];
                ed = opsum_data[e_ch*DW +: DW];
            end
            default: ;
        endcase
        snap_gnt[0] = ifmap_gnt; snap_gnt[1] = ipsum_gnt; snap_gnt[2] = opsum_gnt;
        snap_en = bus.glb_en; snap_web = bus.glb_web; snap_addr = bus.glb_addr;
        snap_wdata = bus.glb_wdata; snap_rdv = bus.rd_valid; snap_rch = bus.rd_ch;
        snap_rcls = bus.rd_cls; snap_rdata = bus.rd_data; snap_busy = bus.busy;
        chk("ifmap_gnt", ifmap_gnt, eg[0]);
        chk("ipsum_gnt", ipsum_gnt, eg[1]);
        chk("opsum_gnt", opsum_gnt, eg[2]);
        chk("glb_en", bus.glb_en, e_cls >= 0);
        chk("glb_addr", bus.glb_addr, ea);
        chk("glb_web", bus.glb_web, ew);
        if (e_cls != 0 && e_cls != 1) chk("glb_wdata", bus.glb_wdata, ed);
        ev = rq.size() > 0 && rq[0].due == cyc;
        eb = (e_cls == 0 || e_cls == 1) || rq.size() > 0;
        chk("busy", bus.busy, eb);
        chk("rd_valid", bus.rd_valid, ev);
        if (ev) begin
            r = rq.pop_front();
            chk("rd_cls", bus.rd_cls, r.cls);
            chk("rd_ch", bus.rd_ch, r.ch);
            chk("rd_data", bus.rd_data, rdata);
        end
        @(posedge clk);
        if (e_cls >= 0) begin
            m_ptr[e_cls] = (e_ch + 1) % N;
            m_last = e_cls;
            if (e_cls < 2) rq.push_back('{cyc + LAT, e_cls, e_ch});
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gnt", {ifmap_gnt, ipsum_gnt, opsum_gnt}, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        m_ptr = '{0, 0, 0};
        m_last = 2;
        rq.delete();
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ifmap_req = '1; ipsum_req = '1; opsum_req = '1;
        do_reset();
        ifmap_req = '0; ipsum_req = '0; opsum_req = '0;

        // Fixed priority: opsum wins, then ifmap ch0.
        prio = 1'b0; ifmap_req = 8'h0F; opsum_req = 8'h04;
        step();
        chk("r038_opsum", snap_gnt[2], 8'h04);
        opsum_req = '0;
        step();
        chk("r038_ifmap", snap_gnt[0], 8'h01);
        ifmap_req = '0;

        do_reset();
        ifmap_req = 8'b1011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r039_rr", snap_gnt[0], exp39[i]);
        end
        ifmap_req = '0;
        repeat (LAT + 1) step();

        do_reset();
        prio = 1'b1; ifmap_req = 8'h01; ipsum_req = 8'h01; opsum_req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r040_cls", {snap_gnt[2][0], snap_gnt[1][0], snap_gnt[0][0]}, 3'b001 << exp40[i]);
        end
        ifmap_req = '0; ipsum_req = '0; opsum_req = '0;
        repeat (LAT + 1) step();

        do_reset();
        prio = 1'b0;
        opsum_addr[7*AW +: AW] = 32'h100;
        opsum_data[7*DW +: DW] = 32'hDEADBEEF;
        opsum_web[7*4 +: 4]    = 4'h0;
        opsum_req = 8'h80;
        step();
        chk("r043_en", snap_en, 1);
        chk("r043_web", snap_web, 4'h0);
        chk("r043_addr", snap_addr, 32'h100);
        chk("r043_wdata", snap_wdata, 32'hDEADBEEF);
        opsum_req = '0;
        repeat (LAT + 1) begin
            step();
            chk("r043_no_ret", snap_rdv, 0);
        end

        do_reset();
        ifmap_req = 8'h04;
        step();
        chk("r041_busy_t", snap_busy, 1);
        ifmap_req = 8'h20;
        step();
        ifmap_req = '0;
        step();
        rdata = 32'hA5;
        step();
        chk("r041_v1", snap_rdv, 1);
        chk("r041_cls1", snap_rcls, 0);
        chk("r041_ch1", snap_rch, 2);
        chk("r041_d1", snap_rdata, 32'hA5);
        rdata = 32'h5A;
        step();
        chk("r041_v2", snap_rdv, 1);
        chk("r041_ch2", snap_rch, 5);
        chk("r041_d2", snap_rdata, 32'h5A);
        chk("r041_busy_t4", snap_busy, 1);
        rdata = '0;
        step();
        chk("r041_idle", snap_busy, 0);

        do_reset();
        ifmap_req = 8'h01;
        step();
        ifmap_req = '0;
        do_reset();
        repeat (LAT + 2) begin
            step();
            chk("r042_no_ret", snap_rdv, 0);
        end
        prio = 1'b1; ifmap_req = '1; ipsum_req = '1; opsum_req = '1;
        step();
        chk("r042_first", snap_gnt[0], 8'h01);

        for (int c = 0; c < N; c++) begin
            ifmap_addr[c*AW +: AW] = $urandom;
            ipsum_addr[c*AW +: AW] = $urandom;
            opsum_addr[c*AW +: AW] = $urandom;
            opsum_data[c*DW +: DW] = $urandom;
            opsum_web[c*4 +: 4]    = 4'($urandom);
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) prio = ~prio;
            ifmap_req = N'($urandom & $urandom);
            ipsum_req = N'($urandom & $urandom);
            opsum_req = N'($urandom & $urandom & $urandom);
            rdata = $urandom;
            step();
        end
        ifmap_req = '0; ipsum_req = '0; opsum_req = '0;
        repeat (LAT + 1) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
